// File: rtl/mlp_seq_ctrl.sv
// Sequential controller for the 2-layer printed MLP classifier: a single shared MAC steps
// through every neuron, fetching weights/biases from an external combinational ROM.
module mlp_seq_ctrl #(
    parameter int unsigned N_IN   = 11,
    parameter int unsigned IN_W   = 4,
    parameter int unsigned N_HID  = 4,
    parameter int unsigned N_OUT  = 7,
    parameter int unsigned W_W    = 8,
    parameter int unsigned B_W    = 16,
    parameter int unsigned SUM0_W = 13,
    parameter int unsigned SUM1_W = 20,
    parameter int unsigned HID_W  = 12,
    parameter int unsigned OUT_W  = 19,
    parameter int unsigned CA_W   = 7,
    parameter int unsigned BA_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*IN_W-1:0]       in_data,
    output logic [CA_W-1:0]            coef_addr,
    input  logic signed [W_W-1:0]      coef_data,
    output logic [BA_W-1:0]            bias_addr,
    input  logic signed [B_W-1:0]      bias_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_class,
    output logic [N_OUT*OUT_W-1:0]     out_scores,
    output logic                       busy
);
    localparam int unsigned ACC_W = 24;
    localparam int unsigned IW    = $clog2(N_IN);
    localparam int unsigned NW    = $clog2((N_OUT > N_HID) ? N_OUT : N_HID);
    localparam int unsigned HW    = $clog2(N_HID);

    typedef enum logic [2:0] {StIdle, StBias, StMac, StWb, StDone} state_e;

    state_e                state_q, state_d;
    logic                  layer_q, layer_d;
    logic [NW-1:0]         neuron_q, neuron_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [N_IN*IN_W-1:0]  feat_q, feat_d;
    logic [HID_W-1:0]      hid_q [N_HID];
    logic [HID_W-1:0]      hid_d [N_HID];
    logic [OUT_W-1:0]      score_q [N_OUT];
    logic [OUT_W-1:0]      score_d [N_OUT];
    logic [OUT_W-1:0]      best_q, best_d;
    logic [2:0]            class_q, class_d;

    logic                  last_idx, last_neuron;
    logic [IN_W-1:0]       feat_op;
    logic [HID_W-1:0]      operand;
    logic [ACC_W-1:0]      product;
    logic [SUM0_W-1:0]     sum0;
    logic [SUM1_W-1:0]     sum1;
    logic [HID_W-1:0]      hid_act;
    logic [OUT_W-1:0]      score_act;

    always_comb begin
        last_idx    = layer_q ? (idx_q == IW'(N_HID - 1)) : (idx_q == IW'(N_IN - 1));
        last_neuron = layer_q ? (neuron_q == NW'(N_OUT - 1)) : (neuron_q == NW'(N_HID - 1));
        feat_op     = feat_q[IN_W*int'(idx_q) +: IN_W];
        operand     = layer_q ? hid_q[idx_q[HW-1:0]] : HID_W'(feat_op);
        // Operand is non-negative; the low ACC_W bits of the product are exact two's complement.
        product     = ACC_W'(operand) * {{(ACC_W-W_W){coef_data[W_W-1]}}, coef_data};
        sum0        = acc_q[SUM0_W-1:0];
        sum1        = acc_q[SUM1_W-1:0];
        hid_act     = sum0[SUM0_W-1] ? '0 : sum0[HID_W-1:0];
        score_act   = sum1[SUM1_W-1] ? '0 : sum1[OUT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        neuron_d  = neuron_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        feat_d    = feat_q;
        hid_d     = hid_q;
        score_d   = score_q;
        best_d    = best_q;
        class_d   = class_q;
        coef_addr = '0;
        bias_addr = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    feat_d   = in_data;
                    layer_d  = 1'b0;
                    neuron_d = '0;
                    state_d  = StBias;
                end
            end
            StBias: begin
                bias_addr = layer_q ? BA_W'(N_HID) + BA_W'(neuron_q) : BA_W'(neuron_q);
                acc_d     = {{(ACC_W-B_W){bias_data[B_W-1]}}, bias_data};
                idx_d     = '0;
                state_d   = StMac;
            end
            StMac: begin
                coef_addr = layer_q
                    ? CA_W'(N_HID*N_IN) + CA_W'(neuron_q)*CA_W'(N_HID) + CA_W'(idx_q)
                    : CA_W'(neuron_q)*CA_W'(N_IN) + CA_W'(idx_q);
                acc_d = acc_q + product;
                if (last_idx) begin
                    state_d = StWb;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StWb: begin
                if (!layer_q) begin
                    hid_d[neuron_q[HW-1:0]] = hid_act;
                end else begin
                    score_d[neuron_q] = score_act;
                    // >= makes ties resolve to the highest index
                    if (neuron_q == '0 || score_act >= best_q) begin
                        best_d  = score_act;
                        class_d = 3'(neuron_q);
                    end
                end
                if (last_neuron) begin
                    neuron_d = '0;
                    layer_d  = 1'b1;
                    state_d  = layer_q ? StDone : StBias;
                end else begin
                    neuron_d = neuron_q + NW'(1);
                    state_d  = StBias;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            layer_q  <= 1'b0;
            neuron_q <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            feat_q   <= '0;
            hid_q    <= '{default: '0};
            score_q  <= '{default: '0};
            best_q   <= '0;
            class_q  <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            feat_q   <= feat_d;
            hid_q    <= hid_d;
            score_q  <= score_d;
            best_q   <= best_d;
            class_q  <= class_d;
        end
    end

    // Results are exposed only in DONE so no partial result is ever visible.
    always_comb begin
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        busy       = (state_q != StIdle) && (state_q != StDone);
        out_class  = out_valid ? class_q : '0;
        out_scores = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (out_valid) begin
                out_scores[(N_OUT-1-k)*OUT_W +: OUT_W] = score_q[k];
            end
        end
    end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Bench for mlp_seq_ctrl: ROM model in the bench, integer reference model of the classifier,
// directed and randomized inferences, backpressure and mid-run reset.
module tb_mlp_seq_ctrl;
    localparam int N_IN  = 11;
    localparam int IN_W  = 4;
    localparam int N_HID = 4;
    localparam int N_OUT = 7;
    localparam int W_W   = 8;
    localparam int B_W   = 16;
    localparam int OUT_W = 19;
    localparam int CA_W  = 7;
    localparam int BA_W  = 4;
    localparam int DW    = N_IN*IN_W;
    localparam int SW    = N_OUT*OUT_W;
    localparam int N_W   = N_HID*N_IN + N_OUT*N_HID;
    localparam int N_B   = N_HID + N_OUT;
    localparam int LAT   = N_HID*(N_IN+2) + N_OUT*(N_HID+2);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        in_data = '0;
    logic [CA_W-1:0]      coef_addr;
    logic signed [W_W-1:0] coef_data;
    logic [BA_W-1:0]      bias_addr;
    logic signed [B_W-1:0] bias_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [2:0]           out_class;
    logic [SW-1:0]        out_scores;
    logic                 busy;

    logic signed [W_W-1:0] rom_w [N_W];
    logic signed [B_W-1:0] rom_b [N_B];

    int n_pass = 0;
    int n_total = 0;

    assign coef_data = (int'(coef_addr) < N_W) ? rom_w[coef_addr] : '0;
    assign bias_data = (int'(bias_addr) < N_B) ? rom_b[bias_addr] : '0;

    always #5 clk = ~clk;

    mlp_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_scores (out_scores),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference classifier: plain integer arithmetic with modular wrap and ReLU.
    function automatic void model(input logic [DW-1:0] din, output logic [SW-1:0] sc,
                                  output logic [2:0] cls);
        int h [N_HID];
        int s;
        int score;
        int best;
        best = -1;
        cls = '0;
        sc = '0;
        for (int j = 0; j < N_HID; j++) begin
            s = rom_b[j];
            for (int i = 0; i < N_IN; i++)
                s += int'(din[IN_W*i +: IN_W]) * int'(rom_w[j*N_IN+i]);
            s = s & 8191;
            h[j] = (s >= 4096) ? 0 : s;
        end
        for (int k = 0; k < N_OUT; k++) begin
            s = rom_b[N_HID+k];
            for (int j = 0; j < N_HID; j++)
                s += h[j] * int'(rom_w[N_HID*N_IN + k*N_HID + j]);
            s = s & ((1 << 20) - 1);
            score = (s >= (1 << 19)) ? 0 : s;
            sc[(N_OUT-1-k)*OUT_W +: OUT_W] = OUT_W'(score);
            if (score >= best) begin
                best = score;
                cls = 3'(k);
            end
        end
    endfunction

    function automatic logic [SW-1:0] pack(input int v [N_OUT]);
        logic [SW-1:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++) r[(N_OUT-1-k)*OUT_W +: OUT_W] = OUT_W'(v[k]);
        return r;
    endfunction

    task automatic rand_rom();
        for (int i = 0; i < N_W; i++) rom_w[i] = W_W'($urandom);
        for (int i = 0; i < N_B; i++) rom_b[i] = B_W'(int'($urandom_range(0, 12000)) - 4000);
    endtask

    task automatic run(input string tag, input logic [DW-1:0] din, input bit bp,
                       output logic [SW-1:0] obs_sc, output logic [2:0] obs_cls);
        logic [SW-1:0] es;
        logic [2:0]    ec;
        int cyc;
        int bad;
        int exp_c [$];
        int exp_b [$];
        model(din, es, ec);
        for (int j = 0; j < N_HID; j++) begin
            exp_c.push_back(0); exp_b.push_back(j);
            for (int i = 0; i < N_IN; i++) begin
                exp_c.push_back(j*N_IN + i); exp_b.push_back(0);
            end
            exp_c.push_back(0); exp_b.push_back(0);
        end
        for (int k = 0; k < N_OUT; k++) begin
            exp_c.push_back(0); exp_b.push_back(N_HID + k);
            for (int j = 0; j < N_HID; j++) begin
                exp_c.push_back(N_HID*N_IN + k*N_HID + j); exp_b.push_back(0);
            end
            exp_c.push_back(0); exp_b.push_back(0);
        end
        in_data = din;
        in_valid = 1'b1;
        out_ready = bp ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = DW'({$urandom, $urandom});
        cyc = 0;
        bad = 0;
        while (!out_valid && cyc < 200) begin
            if (cyc < exp_c.size()) begin
                if (int'(coef_addr) != exp_c[cyc] || int'(bias_addr) != exp_b[cyc] ||
                    busy !== 1'b1 || in_ready !== 1'b0) bad++;
            end
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, 160'(cyc), 160'(LAT));
        check({tag, ":addr_seq"}, 160'(bad), 160'(0));
        check({tag, ":scores"}, 160'(out_scores), 160'(es));
        check({tag, ":class"}, 160'(out_class), 160'(ec));
        obs_sc = out_scores;
        obs_cls = out_class;
        if (bp) begin
            out_ready = 1'b0;
            bad = 0;
            for (int t = 0; t < 20; t++) begin
                in_valid = (t == 5);
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                    out_scores !== es || out_class !== ec) bad++;
            end
            in_valid = 1'b0;
            check({tag, ":bp_hold"}, 160'(bad), 160'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":handoff"}, 160'({in_ready, out_valid, busy}), 160'(3'b100));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [SW-1:0] sc;
        logic [2:0]    cl;
        logic [DW-1:0] din;
        int cv [N_OUT];

        // Reset with random inputs
        rand_rom();
        in_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_data = DW'({$urandom, $urandom});
        repeat (3) @(posedge clk);
        #1;
        check("reset", 160'({in_ready, out_valid, busy, out_class, out_scores, coef_addr, bias_addr}),
              160'({1'b1, 1'b0, 1'b0, 3'b0, {SW{1'b0}}, {CA_W{1'b0}}, {BA_W{1'b0}}}));
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Stand-in ROM reproducing the reference vector for in_data=0
        rand_rom();
        rom_b[0] = 16'sd100; rom_b[1] = -16'sd50; rom_b[2] = 16'sd20; rom_b[3] = 16'sd0;
        for (int k = 0; k < N_OUT; k++) begin
            rom_w[N_HID*N_IN + k*N_HID + 0] = 8'sd2;
            rom_w[N_HID*N_IN + k*N_HID + 2] = -8'sd3;
        end
        rom_b[4] = -16'sd500; rom_b[5] = -16'sd140; rom_b[6] = 16'sd15136;
        rom_b[7] = 16'sd17625; rom_b[8] = 16'sd4531; rom_b[9] = 16'sd660; rom_b[10] = -16'sd1000;
        run("ref", '0, 1'b0, sc, cl);
        cv = '{0, 0, 15276, 17765, 4671, 800, 0};
        check("ref:const_scores", 160'(sc), 160'(pack(cv)));
        check("ref:const_class", 160'(cl), 160'(3));

        // Tie: all scores equal resolve to the highest index
        for (int i = 0; i < N_W; i++) rom_w[i] = '0;
        for (int i = 0; i < N_B; i++) rom_b[i] = (i < N_HID) ? 16'sd0 : 16'sd5;
        run("tie", DW'({$urandom, $urandom}), 1'b0, sc, cl);
        cv = '{5, 5, 5, 5, 5, 5, 5};
        check("tie:const_scores", 160'(sc), 160'(pack(cv)));
        check("tie:const_class", 160'(cl), 160'(6));

        // Wrap: layer-0 sum 5905 wraps negative, so h_0 = 0
        for (int i = 0; i < N_W; i++) rom_w[i] = '0;
        for (int i = 0; i < N_B; i++) rom_b[i] = '0;
        rom_b[0] = 16'sd4000;
        rom_w[0] = 8'sd127;
        for (int k = 0; k < N_OUT; k++) begin
            rom_w[N_HID*N_IN + k*N_HID] = 8'sd1;
            rom_b[N_HID + k] = B_W'(100 + 10*k);
        end
        din = DW'({$urandom, $urandom});
        din[IN_W-1:0] = 4'd15;
        run("wrap", din, 1'b0, sc, cl);
        cv = '{100, 110, 120, 130, 140, 150, 160};
        check("wrap:const_scores", 160'(sc), 160'(pack(cv)));
        check("wrap:const_class", 160'(cl), 160'(6));

        // Randomized ROMs and features, one with result backpressure
        for (int r = 0; r < 5; r++) begin
            rand_rom();
            run($sformatf("rand%0d", r), DW'({$urandom, $urandom}), (r == 2), sc, cl);
        end

        // Mid-run reset at cycle 40, then a fresh inference
        rand_rom();
        din = DW'({$urandom, $urandom});
        in_data = din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("midrun:busy", 160'({busy, in_ready}), 160'(2'b10));
        rst_n = 1'b0;
        #1;
        check("midrun:reset",
              160'({in_ready, out_valid, busy, out_class, out_scores, coef_addr, bias_addr}),
              160'({1'b1, 1'b0, 1'b0, 3'b0, {SW{1'b0}}, {CA_W{1'b0}}, {BA_W{1'b0}}}));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_reset", DW'({$urandom, $urandom}), 1'b0, sc, cl);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
